operand_b_ctrl: RTL and testbench

//  Controls the EX-stage operand-B mux that picks register data or immediate.

---
 rtl/operand_b_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_operand_b_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_b_ctrl.sv
// Purpose : picks the EX-stage operand-B source (reg / imm / fwd EX-MEM / fwd WB) and interlocks load-use hazards.
// Latency : select and bubble flag are registered into EX one clock after ID; Stall_o is combinational in ID.
// Backpressure: Stall_o holds PC and IF/ID; a stalled or flushed ID slot injects a bubble into EX.
//
// Build option: define OPB_FWD_EN to enable forwarding (selects 10/11) with a one-cycle
// load-use stall. Without it the block is a pure interlock: selects are only 00/01 and any
// EX or MEM producer match stalls ID until the producer has reached write-back.
//
// Ports:
//   Clk_i, Rst_i      core clock, synchronous active-high reset
//   IdValid_i         ID holds a valid instruction
//   BSel_i            decoder operand-B select (1 = immediate)
//   Rs2Addr_i/Rs2Used_i  ID source register and whether it is read
//   RdAddr_i/RegWrite_i/MemRead_i  ID destination, write enable, load flag
//   Flush_i           branch/jump flush of ID and EX (beats stall)
//   BSelSel_o         registered operand-B select for EX
//   Stall_o           hold PC and IF/ID this cycle
//   Bubble_o          registered: EX holds an injected NOP
module operand_b_ctrl #(
  parameter int REG_AW = 5,
  parameter int BSEL_W = 2
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              IdValid_i,
  input  logic              BSel_i,
  input  logic [REG_AW-1:0] Rs2Addr_i,
  input  logic              Rs2Used_i,
  input  logic [REG_AW-1:0] RdAddr_i,
  input  logic              RegWrite_i,
  input  logic              MemRead_i,
  input  logic              Flush_i,
  output logic [BSEL_W-1:0] BSelSel_o,
  output logic              Stall_o,
  output logic              Bubble_o
);

  localparam logic BSEL_IMM = 1'b1;

  localparam logic [BSEL_W-1:0] SEL_REG    = BSEL_W'(0);
  localparam logic [BSEL_W-1:0] SEL_IMM    = BSEL_W'(1);
  localparam logic [BSEL_W-1:0] SEL_FWD_EX = BSEL_W'(2);
  localparam logic [BSEL_W-1:0] SEL_FWD_WB = BSEL_W'(3);

  // Producer tracking slot for one pipeline stage.
  typedef struct packed {
    logic              vld;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } slot_t;

  slot_t             ex_q, ex_d;
  slot_t             mem_q;
  logic [BSEL_W-1:0] bsel_q, bsel_d;
  logic              bubble_q, bubble_d;

  logic              rs2_chk;
  logic              ex_match;
  logic              mem_match;
  logic              ex_load;
  logic [BSEL_W-1:0] sel_id;

  // An immediate operand or x0 never depends on an older producer.
  assign rs2_chk   = Rs2Used_i && (BSel_i != BSEL_IMM) && (Rs2Addr_i != '0);
  assign ex_match  = rs2_chk && ex_q.vld  && ex_q.we  && (ex_q.rd  == Rs2Addr_i);
  assign mem_match = rs2_chk && mem_q.vld && mem_q.we && (mem_q.rd == Rs2Addr_i);

`ifdef OPB_FWD_EN

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_LDSTALL = 1'b1
  } state_t;

  state_t state_q, state_d;
  logic   load_use;
  logic   unused_ld;

  // Load data only exists at WB, so a load in EX cannot be forwarded yet.
  assign load_use = ex_match && ex_q.ld && IdValid_i && !Flush_i;

  // The MEM-slot load flag is tracked for completeness but only EX needs it here.
  assign unused_ld = mem_q.ld;

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:     if (load_use) state_d = ST_LDSTALL;
      // One bubble is enough: the load has moved to MEM and now forwards from WB.
      ST_LDSTALL: state_d = ST_RUN;
      default:    state_d = ST_RUN;
    endcase
  end

  always_comb begin
    Stall_o = 1'b0;
    if ((state_q == ST_RUN) && load_use && !Rst_i) begin
      Stall_o = 1'b1;
    end
  end

  // EX producer is younger than MEM, so it wins when both match.
  always_comb begin
    sel_id = SEL_REG;
    if (BSel_i == BSEL_IMM) begin
      sel_id = SEL_IMM;
    end else if (ex_match) begin
      sel_id = SEL_FWD_EX;
    end else if (mem_match) begin
      sel_id = SEL_FWD_WB;
    end
  end

`else

  logic [1:0] cnt_q, cnt_d;
  logic       unused_ld;

  // Without forwarding the load flag is irrelevant: every producer is waited out.
  assign unused_ld = ex_q.ld ^ mem_q.ld;

  // cnt_q holds the number of further stall cycles still owed after this one.
  always_comb begin
    Stall_o = 1'b0;
    if (IdValid_i && !Flush_i && !Rst_i && (ex_match || mem_match || (cnt_q != 2'd0))) begin
      Stall_o = 1'b1;
    end
  end

  // A producer in EX needs one more cycle (through MEM) before the register
  // file writes through at WB; a producer in MEM needs none.
  always_comb begin
    cnt_d = 2'd0;
    if (Stall_o) begin
      if (ex_match) begin
        cnt_d = 2'd1;
      end else if (cnt_q != 2'd0) begin
        cnt_d = cnt_q - 2'd1;
      end
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i || Flush_i) begin
      cnt_q <= 2'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    sel_id = SEL_REG;
    if (BSel_i == BSEL_IMM) begin
      sel_id = SEL_IMM;
    end
  end

`endif

  // ID advances into EX only when it is valid, not held and not flushed;
  // everything else becomes a bubble with a neutral select.
  assign ex_load = IdValid_i && !Stall_o && !Flush_i;

  always_comb begin
    ex_d     = '0;
    bsel_d   = SEL_REG;
    bubble_d = 1'b1;
    if (ex_load) begin
      ex_d.vld = 1'b1;
      ex_d.rd  = RdAddr_i;
      ex_d.we  = RegWrite_i;
      ex_d.ld  = MemRead_i;
      bsel_d   = sel_id;
      bubble_d = 1'b0;
    end
  end

  always_ff @(posedge Clk_i) begin
    if (Rst_i) begin
      ex_q     <= '0;
      mem_q    <= '0;
      bsel_q   <= SEL_REG;
      bubble_q <= 1'b0;
    end else begin
      ex_q     <= ex_d;
      mem_q    <= ex_q;
      bsel_q   <= bsel_d;
      bubble_q <= bubble_d;
    end
  end

  assign BSelSel_o = bsel_q;
  assign Bubble_o  = bubble_q;

  a_flush_no_stall: assert property (@(posedge Clk_i) Flush_i |-> !Stall_o);
  a_bubble_neutral: assert property (@(posedge Clk_i) disable iff (Rst_i) Bubble_o |-> (BSelSel_o == SEL_REG));

endmodule

// File: tb/tb_operand_b_ctrl.sv
// Purpose : directed scoreboard bench for operand_b_ctrl (forwarding or interlock build).
// Latency : expected select queued when ID is accepted, compared one clock later in EX.
// Backpressure: stall cycles are counted per instruction and compared with the expected count.
module tb_operand_b_ctrl;

  localparam int REG_AW = 5;
  localparam int BSEL_W = 2;

`ifdef OPB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              Clk_i = 1'b0;
  logic              Rst_i = 1'b1;
  logic              IdValid_i = 1'b0;
  logic              BSel_i = 1'b0;
  logic [REG_AW-1:0] Rs2Addr_i = '0;
  logic              Rs2Used_i = 1'b0;
  logic [REG_AW-1:0] RdAddr_i = '0;
  logic              RegWrite_i = 1'b0;
  logic              MemRead_i = 1'b0;
  logic              Flush_i = 1'b0;
  logic [BSEL_W-1:0] BSelSel_o;
  logic              Stall_o;
  logic              Bubble_o;

  operand_b_ctrl #(.REG_AW(REG_AW), .BSEL_W(BSEL_W)) dut (
    .Clk_i      (Clk_i),
    .Rst_i      (Rst_i),
    .IdValid_i  (IdValid_i),
    .BSel_i     (BSel_i),
    .Rs2Addr_i  (Rs2Addr_i),
    .Rs2Used_i  (Rs2Used_i),
    .RdAddr_i   (RdAddr_i),
    .RegWrite_i (RegWrite_i),
    .MemRead_i  (MemRead_i),
    .Flush_i    (Flush_i),
    .BSelSel_o  (BSelSel_o),
    .Stall_o    (Stall_o),
    .Bubble_o   (Bubble_o)
  );

  always #5 Clk_i = ~Clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];
  bit prev_loaded = 1'b0;
  bit prev_reset  = 1'b1;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Negedge sample: check what the last posedge put into EX, return current Stall_o.
  task automatic sample(input string tag, output bit stall);
    int e;
    @(negedge Clk_i);
    if (prev_reset) begin
      check_val({tag, " rst_sel"}, int'(BSelSel_o), 0);
      check_val({tag, " rst_bubble"}, int'(Bubble_o), 0);
    end else if (prev_loaded) begin
      e = exp_q.pop_front();
      check_val({tag, " sel"}, int'(BSelSel_o), e);
      check_val({tag, " bubble"}, int'(Bubble_o), 0);
    end else begin
      check_val({tag, " bub_sel"}, int'(BSelSel_o), 0);
      check_val({tag, " bub_bubble"}, int'(Bubble_o), 1);
    end
    stall = Stall_o;
  endtask

  task automatic advance(input bit loaded);
    prev_loaded = loaded;
    prev_reset  = Rst_i;
    @(posedge Clk_i);
    #1;
  endtask

  task automatic drive(input bit used, input bit bsel, input int rs2, input int rd,
                       input bit we, input bit ld);
    IdValid_i  = 1'b1;
    Rs2Used_i  = used;
    BSel_i     = bsel;
    Rs2Addr_i  = REG_AW'(rs2);
    RdAddr_i   = REG_AW'(rd);
    RegWrite_i = we;
    MemRead_i  = ld;
  endtask

  // Present one instruction in ID until accepted; exp_sel is queued for its EX cycle.
  task automatic issue(input string tag, input bit used, input bit bsel, input int rs2,
                       input int rd, input bit we, input bit ld,
                       input int exp_sel, input int exp_stalls);
    bit st;
    int n;
    n = 0;
    drive(used, bsel, rs2, rd, we, ld);
    sample(tag, st);
    while (st && (n < 4)) begin
      n++;
      advance(1'b0);
      sample(tag, st);
    end
    check_val({tag, " stalls"}, n, exp_stalls);
    if (st) begin
      IdValid_i = 1'b0;
      advance(1'b0);
    end else begin
      exp_q.push_back(exp_sel);
      advance(1'b1);
    end
    IdValid_i = 1'b0;
  endtask

  task automatic idle(input int cycles);
    bit st;
    IdValid_i = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      sample("idle", st);
      check_val("idle stall", int'(st), 0);
      advance(1'b0);
    end
  endtask

  // Hazarding instruction presented together with a flush: must not stall, EX gets a bubble.
  task automatic flush_probe(input string tag, input int rs2);
    bit st;
    drive(1'b1, 1'b0, rs2, 8, 1'b1, 1'b0);
    Flush_i = 1'b1;
    sample(tag, st);
    check_val({tag, " stall"}, int'(st), 0);
    advance(1'b0);
    Flush_i   = 1'b0;
    IdValid_i = 1'b0;
  endtask

  // Hazarding instruction presented together with reset: stall drops the same cycle.
  task automatic reset_probe(input string tag, input int rs2);
    bit st;
    drive(1'b1, 1'b0, rs2, 8, 1'b1, 1'b0);
    Rst_i = 1'b1;
    sample(tag, st);
    check_val({tag, " stall"}, int'(st), 0);
    advance(1'b0);
    Rst_i     = 1'b0;
    IdValid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles.
    Rst_i = 1'b1;
    repeat (2) @(posedge Clk_i);
    #1;
    prev_reset = 1'b1;
    Rst_i = 1'b0;
    idle(2);

    // addi x5 ; add x6,x1,x5
    issue("t2_addi", 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1, 0);
    issue("t2_add",  1'b1, 1'b0, 5, 6, 1'b1, 1'b0, FWD ? 2 : 0, FWD ? 0 : 2);
    idle(2);

    // addi x5 ; nop ; add x6,x1,x5
    issue("t3_addi", 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1, 0);
    idle(1);
    issue("t3_add",  1'b1, 1'b0, 5, 6, 1'b1, 1'b0, FWD ? 3 : 0, FWD ? 0 : 1);
    idle(2);

    // addi x5 ; addi x5 ; add -> youngest producer wins
    issue("t3b_addi0", 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1, 0);
    issue("t3b_addi1", 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1, 0);
    issue("t3b_add",   1'b1, 1'b0, 5, 6, 1'b1, 1'b0, FWD ? 2 : 0, FWD ? 0 : 2);
    idle(2);

    // lw x7 ; sub x8,x2,x7
    issue("t4_lw",  1'b0, 1'b1, 0, 7, 1'b1, 1'b1, 1, 0);
    issue("t4_sub", 1'b1, 1'b0, 7, 8, 1'b1, 1'b0, FWD ? 3 : 0, FWD ? 1 : 2);
    idle(2);

    // writer x0, reader of x0
    issue("t5_wx0", 1'b0, 1'b1, 0, 0, 1'b1, 1'b0, 1, 0);
    issue("t5_rx0", 1'b1, 1'b0, 0, 6, 1'b1, 1'b0, 0, 0);
    idle(2);

    // rs2 matches but operand is an immediate
    issue("t5_addi", 1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1, 0);
    issue("t5_imm",  1'b1, 1'b1, 5, 6, 1'b1, 1'b0, 1, 0);
    idle(2);

    // producer without write enable
    issue("t5_st",  1'b0, 1'b1, 0, 5, 1'b0, 1'b0, 1, 0);
    issue("t5_rst", 1'b1, 1'b0, 5, 6, 1'b1, 1'b0, 0, 0);
    idle(2);

    // reader that does not use rs2
    issue("t5_w5",   1'b0, 1'b1, 0, 5, 1'b1, 1'b0, 1, 0);
    issue("t5_nors", 1'b0, 1'b0, 5, 6, 1'b1, 1'b0, 0, 0);
    idle(2);

    // Flush on the load-use hazard cycle, then the load sits in MEM
    issue("t6_lw", 1'b0, 1'b1, 0, 7, 1'b1, 1'b1, 1, 0);
    flush_probe("t6_flush", 7);
    issue("t6_sub", 1'b1, 1'b0, 7, 8, 1'b1, 1'b0, FWD ? 3 : 0, FWD ? 0 : 1);
    idle(2);
    issue("t6_lw2",  1'b0, 1'b1, 0, 9, 1'b1, 1'b1, 1, 0);
    issue("t6_sub2", 1'b1, 1'b0, 9, 8, 1'b1, 1'b0, FWD ? 3 : 0, FWD ? 1 : 2);
    idle(2);

    // Reset on the hazard cycle clears the tracking slots
    issue("t7_lw", 1'b0, 1'b1, 0, 7, 1'b1, 1'b1, 1, 0);
    reset_probe("t7_rst", 7);
    issue("t7_sub", 1'b1, 1'b0, 7, 8, 1'b1, 1'b0, 0, 0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
